// File: rtl/fde_if.sv
// Handshake/bus bundle of the fde_unit front end: start/PC, fetch port,
// register-file read port and the completed-instruction result bus.
interface fde_if;
  logic        start;
  logic [31:0] pc;
  logic        fetch_req_en;
  logic [31:0] fetch_req_addr;
  logic        fetch_resp_en;
  logic [31:0] fetch_resp_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_val, rs2_val;
  logic        done;
  logic [31:0] pc_out, instr_out, result, store_data;
  logic [4:0]  rd;
  logic        rd_we, is_load, is_store;
  logic [2:0]  load_store_funct3;
  logic        jump_taken;
  logic [31:0] jump_dest;
  logic        illegal, fault;

  modport master (
    output start, pc, fetch_resp_en, fetch_resp_data, rs1_val, rs2_val,
    input  fetch_req_en, fetch_req_addr, rs1_addr, rs2_addr, done, pc_out,
           instr_out, result, store_data, rd, rd_we, is_load, is_store,
           load_store_funct3, jump_taken, jump_dest, illegal, fault
  );

  modport slave (
    input  start, pc, fetch_resp_en, fetch_resp_data, rs1_val, rs2_val,
    output fetch_req_en, fetch_req_addr, rs1_addr, rs2_addr, done, pc_out,
           instr_out, result, store_data, rd, rd_we, is_load, is_store,
           load_store_funct3, jump_taken, jump_dest, illegal, fault
  );
endinterface

// File: rtl/fde_unit.sv
// RV32I fetch/decode/execute front end, one instruction at a time.
// Optional macro RV32M_EN adds the M extension in the EXEC cycle.
module fde_unit #(
  parameter int FETCH_TIMEOUT = 255
) (
  input logic  clk,
  input logic  rst,
  fde_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, DONE} state_t;

  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_FENCE = 7'b0001111;

  state_t      state;
  logic [31:0] pc_q, instr_q, tmo_cnt, rs1_q, rs2_q;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] opb, pc4;
  logic        is_reg, alt_ok, base_ok, br_cond;
  logic [31:0] x_result, x_jd;
  logic        x_jt, x_we, x_ld, x_st, x_ill;
  logic        tmo_hit, abort;
  logic [31:0] abort_pc;

  assign opc    = instr_q[6:0];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign is_reg = (opc == OP_REG);
  assign opb    = is_reg ? rs2_q : imm_i;
  assign pc4    = pc_q + 32'd4;
  // funct7=0100000 is only meaningful for SUB and SRA/SRAI
  assign alt_ok  = (f7 == 7'b0100000) && ((f3 == 3'b000 && is_reg) || f3 == 3'b101);
  assign base_ok = (f7 == 7'b0000000) || (!is_reg && f3 != 3'b001 && f3 != 3'b101);

`ifdef RV32M_EN
  logic [63:0] p_ss, p_su, p_uu;
  logic [31:0] m_result;
  logic        div_ovf;
  assign p_ss    = {{32{rs1_q[31]}}, rs1_q} * {{32{rs2_q[31]}}, rs2_q};
  assign p_su    = {{32{rs1_q[31]}}, rs1_q} * {32'b0, rs2_q};
  assign p_uu    = {32'b0, rs1_q} * {32'b0, rs2_q};
  assign div_ovf = (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);

  always_comb begin
    m_result = 32'd0;
    case (f3)
      3'd0: m_result = p_uu[31:0];
      3'd1: m_result = p_ss[63:32];
      3'd2: m_result = p_su[63:32];
      3'd3: m_result = p_uu[63:32];
      3'd4: m_result = (rs2_q == 0) ? 32'hFFFF_FFFF : div_ovf ? 32'h8000_0000
                     : 32'($signed(rs1_q) / $signed(rs2_q));
      3'd5: m_result = (rs2_q == 0) ? 32'hFFFF_FFFF : rs1_q / rs2_q;
      3'd6: m_result = (rs2_q == 0) ? rs1_q : div_ovf ? 32'd0
                     : 32'($signed(rs1_q) % $signed(rs2_q));
      default: m_result = (rs2_q == 0) ? rs1_q : rs1_q % rs2_q;
    endcase
  end
`endif

  always_comb begin
    case (f3)
      3'b000:  br_cond = (rs1_q == rs2_q);
      3'b001:  br_cond = (rs1_q != rs2_q);
      3'b100:  br_cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  br_cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_cond = (rs1_q <  rs2_q);
      default: br_cond = (rs1_q >= rs2_q);
    endcase
  end

  always_comb begin
    x_result = 32'd0;
    x_jd     = pc4;
    x_jt     = 1'b0;
    x_we     = 1'b0;
    x_ld     = 1'b0;
    x_st     = 1'b0;
    x_ill    = 1'b0;
    case (opc)
      OP_REG, OP_IMM: begin
        x_we = 1'b1;
        if (is_reg && f7 == 7'b0000001) begin
`ifdef RV32M_EN
          x_result = m_result;
`else
          x_ill = 1'b1;
`endif
        end else if (!(alt_ok || base_ok)) begin
          x_ill = 1'b1;
        end else begin
          case (f3)
            3'b000:  x_result = alt_ok ? rs1_q - opb : rs1_q + opb;
            3'b001:  x_result = rs1_q << opb[4:0];
            3'b010:  x_result = {31'd0, $signed(rs1_q) < $signed(opb)};
            3'b011:  x_result = {31'd0, rs1_q < opb};
            3'b100:  x_result = rs1_q ^ opb;
            3'b101:  x_result = alt_ok ? 32'($signed(rs1_q) >>> opb[4:0]) : rs1_q >> opb[4:0];
            3'b110:  x_result = rs1_q | opb;
            default: x_result = rs1_q & opb;
          endcase
        end
      end
      OP_LUI:   begin x_we = 1'b1; x_result = imm_u; end
      OP_AUIPC: begin x_we = 1'b1; x_result = pc_q + imm_u; end
      OP_JAL:   begin x_we = 1'b1; x_result = pc4; x_jt = 1'b1; x_jd = pc_q + imm_j; end
      OP_JALR: begin
        if (f3 != 3'b000) x_ill = 1'b1;
        else begin
          x_we = 1'b1; x_result = pc4; x_jt = 1'b1;
          x_jd = (rs1_q + imm_i) & ~32'd1;
        end
      end
      OP_BR: begin
        if (f3 == 3'b010 || f3 == 3'b011) x_ill = 1'b1;
        else begin
          x_jt = br_cond;
          if (br_cond) x_jd = pc_q + imm_b;
        end
      end
      OP_LD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) x_ill = 1'b1;
        else begin x_we = 1'b1; x_ld = 1'b1; x_result = rs1_q + imm_i; end
      end
      OP_ST: begin
        if (f3[2] || f3 == 3'b011) x_ill = 1'b1;
        else begin x_st = 1'b1; x_result = rs1_q + imm_s; end
      end
      OP_FENCE: x_ill = (f3 != 3'b000);
      default:  x_ill = 1'b1;
    endcase
    if (x_ill) begin
      x_result = 32'd0; x_jd = pc4; x_jt = 1'b0;
      x_we = 1'b0; x_ld = 1'b0; x_st = 1'b0;
    end
    if (instr_q[11:7] == 5'd0) x_we = 1'b0;
  end

  assign bus.fetch_req_addr = pc_q;
  assign tmo_hit  = (FETCH_TIMEOUT != 0) && (tmo_cnt == 32'(FETCH_TIMEOUT - 1));
  // Misaligned start and fetch timeout both finish straight into DONE with fault
  assign abort    = (state == IDLE && bus.start && bus.pc[1:0] != 2'b00) ||
                    (state == FETCH_WAIT && !bus.fetch_resp_en && tmo_hit);
  assign abort_pc = (state == IDLE) ? bus.pc : pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q <= '0; instr_q <= '0; tmo_cnt <= '0; rs1_q <= '0; rs2_q <= '0;
      imm_i <= '0; imm_s <= '0; imm_b <= '0; imm_u <= '0; imm_j <= '0;
      bus.fetch_req_en <= 1'b0; bus.rs1_addr <= '0; bus.rs2_addr <= '0;
      bus.done <= 1'b0; bus.pc_out <= '0; bus.instr_out <= '0;
      bus.result <= '0; bus.store_data <= '0; bus.rd <= '0; bus.rd_we <= 1'b0;
      bus.is_load <= 1'b0; bus.is_store <= 1'b0; bus.load_store_funct3 <= '0;
      bus.jump_taken <= 1'b0; bus.jump_dest <= '0; bus.illegal <= 1'b0;
      bus.fault <= 1'b0;
    end else begin
      bus.fetch_req_en <= 1'b0;
      bus.done         <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          pc_q    <= bus.pc;
          tmo_cnt <= '0;
          state   <= FETCH_REQ;
          bus.fetch_req_en <= 1'b1;
        end
        FETCH_REQ: state <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (bus.fetch_resp_en) begin
            instr_q      <= bus.fetch_resp_data;
            bus.rs1_addr <= bus.fetch_resp_data[19:15];
            bus.rs2_addr <= bus.fetch_resp_data[24:20];
            state        <= DECODE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        DECODE: begin
          rs1_q <= bus.rs1_val;
          rs2_q <= bus.rs2_val;
          imm_i <= {{20{instr_q[31]}}, instr_q[31:20]};
          imm_s <= {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
          imm_b <= {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
          imm_u <= {instr_q[31:12], 12'd0};
          imm_j <= {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
          state <= EXEC;
        end
        EXEC: begin
          bus.done <= 1'b1; bus.fault <= 1'b0;
          bus.pc_out <= pc_q; bus.instr_out <= instr_q;
          bus.result <= x_result; bus.store_data <= rs2_q;
          bus.rd <= instr_q[11:7]; bus.rd_we <= x_we;
          bus.is_load <= x_ld; bus.is_store <= x_st; bus.load_store_funct3 <= f3;
          bus.jump_taken <= x_jt; bus.jump_dest <= x_jd; bus.illegal <= x_ill;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        state <= DONE;
        bus.fetch_req_en <= 1'b0;
        bus.done <= 1'b1; bus.fault <= 1'b1;
        bus.pc_out <= abort_pc; bus.instr_out <= '0;
        bus.result <= '0; bus.store_data <= '0; bus.rd <= '0; bus.rd_we <= 1'b0;
        bus.is_load <= 1'b0; bus.is_store <= 1'b0; bus.load_store_funct3 <= '0;
        bus.jump_taken <= 1'b0; bus.jump_dest <= '0; bus.illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fde_unit.sv
// Self-checking bench for fde_unit: directed vector table, fault/reset
// sequences and random instructions checked against an ISA-level model.
module tb_fde_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fde_if bus();
  fde_unit #(.FETCH_TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [32];
  assign bus.rs1_val = rf[bus.rs1_addr];
  assign bus.rs2_val = rf[bus.rs2_addr];

  int nvec = 0, nerr = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] result, jd;
    logic jt, we, ld, st, ill;
  } exp_t;

  typedef struct {
    logic [31:0] pc, ins, r1, r2;
    int          dly;
    logic [31:0] res, jd;
    logic        jt, we, ill;
  } vec_t;

`ifdef RV32M_EN
  function automatic logic [31:0] mext(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] pr;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
    case (f3)
      3'd0: begin pr = sx * sy; return pr[31:0]; end
      3'd1: begin pr = sx * sy; return pr[63:32]; end
      3'd2: begin pr = sx * uy; return pr[63:32]; end
      3'd3: begin pr = ux * uy; return pr[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
      3'd6: return (y == 0) ? x : 32'(sx % sy);
      default: return (y == 0) ? x : 32'(ux % uy);
    endcase
  endfunction
`endif

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] b);
    case (f3)
      3'd0: return x + b;
      3'd1: return x << b[4:0];
      3'd2: return ($signed(x) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (x < b) ? 32'd1 : 32'd0;
      3'd4: return x ^ b;
      3'd5: return x >> b[4:0];
      3'd6: return x | b;
      default: return x & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] ii, is, ib, iu, ij, b;
    logic wr, ill, t;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    e.result = 0; e.jd = p + 4; e.jt = 0; e.ld = 0; e.st = 0; wr = 0; ill = 0; t = 0;
    case (op)
      7'h33, 7'h13: begin
        b = (op == 7'h33) ? y : ii;
        wr = 1;
        if (op == 7'h33 && f7 == 7'h01) begin
`ifdef RV32M_EN
          e.result = mext(f3, x, y);
`else
          ill = 1;
`endif
        end else if (op == 7'h33 || f3 == 3'd1 || f3 == 3'd5) begin
          if (f7 == 7'h20 && op == 7'h33 && f3 == 3'd0) e.result = x - b;
          else if (f7 == 7'h20 && f3 == 3'd5) e.result = 32'($signed(x) >>> b[4:0]);
          else if (f7 == 7'h00) e.result = alu(f3, x, b);
          else ill = 1;
        end else e.result = alu(f3, x, b);
      end
      7'h37: begin wr = 1; e.result = iu; end
      7'h17: begin wr = 1; e.result = p + iu; end
      7'h6F: begin wr = 1; e.result = p + 4; e.jt = 1; e.jd = p + ij; end
      7'h67: if (f3 == 0) begin wr = 1; e.result = p + 4; e.jt = 1; e.jd = (x + ii) & 32'hFFFF_FFFE; end
             else ill = 1;
      7'h63: begin
        case (f3)
          3'd0: t = (x == y);
          3'd1: t = (x != y);
          3'd4: t = ($signed(x) < $signed(y));
          3'd5: t = ($signed(x) >= $signed(y));
          3'd6: t = (x < y);
          3'd7: t = (x >= y);
          default: ill = 1;
        endcase
        e.jt = t;
        if (t) e.jd = p + ib;
      end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin wr = 1; e.ld = 1; e.result = x + ii; end
             else ill = 1;
      7'h23: if (f3 inside {3'd0, 3'd1, 3'd2}) begin e.st = 1; e.result = x + is; end
             else ill = 1;
      7'h0F: ill = (f3 != 0);
      default: ill = 1;
    endcase
    if (ill) begin
      e.result = 0; e.jd = p + 4; e.jt = 0; e.ld = 0; e.st = 0; wr = 0;
    end
    e.ill = ill;
    e.we = wr && (ins[11:7] != 0);
    return e;
  endfunction

  // Starts one instruction and answers the fetch `delay` cycles after the
  // earliest slot (delay<0: never). lat = cycle in which done is seen.
  task automatic issue(input logic [31:0] p, input logic [31:0] ins, input int delay,
                       output int lat, output int nreq);
    int resp_c;
    resp_c = -1; lat = -1; nreq = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pc = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.fetch_req_en) begin
        nreq++;
        chk("req_addr", bus.fetch_req_addr, p);
        if (delay >= 0) resp_c = c + 1 + delay;
      end
      bus.fetch_resp_en   = (c == resp_c);
      bus.fetch_resp_data = (c == resp_c) ? ins : $urandom;
      if (bus.done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    bus.fetch_resp_en = 1'b0;
  endtask

  task automatic check_model(input logic [31:0] p, input logic [31:0] ins);
    exp_t e;
    e = model(p, ins, rf[ins[19:15]], rf[ins[24:20]]);
    chk("rnd.result", bus.result, e.result);
    chk("rnd.jump_dest", bus.jump_dest, e.jd);
    chk("rnd.jump_taken", 32'(bus.jump_taken), 32'(e.jt));
    chk("rnd.rd_we", 32'(bus.rd_we), 32'(e.we));
    chk("rnd.is_load", 32'(bus.is_load), 32'(e.ld));
    chk("rnd.is_store", 32'(bus.is_store), 32'(e.st));
    chk("rnd.illegal", 32'(bus.illegal), 32'(e.ill));
    chk("rnd.fault", 32'(bus.fault), 0);
    chk("rnd.rd", 32'(bus.rd), 32'(ins[11:7]));
    chk("rnd.funct3", 32'(bus.load_store_funct3), 32'(ins[14:12]));
    chk("rnd.pc_out", bus.pc_out, p);
    chk("rnd.instr_out", bus.instr_out, ins);
    chk("rnd.store_data", bus.store_data, rf[ins[24:20]]);
  endtask

  vec_t tbl [14];
  int lat, nreq, ndone;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p, ins, body;
    logic [6:0]  ops [11];
    logic [6:0]  f7s;

    bus.start = 0; bus.pc = 0; bus.fetch_resp_en = 0; bus.fetch_resp_data = 0;
    for (int i = 0; i < 32; i++) rf[i] = 0;

    tbl[0]  = '{32'h100, 32'h00500093, 0, 0, 0, 32'd5, 32'h104, 0, 1, 0};
    tbl[1]  = '{32'h200, 32'h00208863, 7, 7, 0, 0, 32'h210, 1, 0, 0};
    tbl[2]  = '{32'h200, 32'h00208863, 7, 8, 2, 0, 32'h204, 0, 0, 0};
    tbl[3]  = '{32'h040, 32'h005100E7, 32'h1000, 0, 0, 32'h44, 32'h1004, 1, 1, 0};
    tbl[4]  = '{32'h300, 32'h002081B3, 32'hFFFF_FFFF, 2, 3, 32'd1, 32'h304, 0, 1, 0};
    tbl[5]  = '{32'h304, 32'h402081B3, 5, 7, 1, 32'hFFFF_FFFE, 32'h308, 0, 1, 0};
    tbl[6]  = '{32'h400, 32'h123452B7, 0, 0, 0, 32'h1234_5000, 32'h404, 0, 1, 0};
    tbl[7]  = '{32'h404, 32'h0020A423, 32'h1000, 32'hABCD, 0, 32'h1008, 32'h408, 0, 0, 0};
`ifdef RV32M_EN
    tbl[8]  = '{32'h500, 32'h0220C1B3, 32'h1234, 0, 0, 32'hFFFF_FFFF, 32'h504, 0, 1, 0};
`else
    tbl[8]  = '{32'h500, 32'h0220C1B3, 32'h1234, 0, 0, 0, 32'h504, 0, 0, 1};
`endif
    tbl[9]  = '{32'h600, 32'h00000073, 0, 0, 0, 0, 32'h604, 0, 0, 1};
    tbl[10] = '{32'h700, 32'h00100013, 0, 0, 0, 32'd1, 32'h704, 0, 0, 0};
    tbl[11] = '{32'h800, 32'hFFC0A203, 32'h2000, 0, 0, 32'h1FFC, 32'h804, 0, 1, 0};
    tbl[12] = '{32'h900, 32'h4040D313, 32'h8000_0000, 0, 0, 32'hF800_0000, 32'h904, 0, 1, 0};
    tbl[13] = '{32'h100, 32'hFF9FF0EF, 0, 0, 0, 32'h104, 32'h0F8, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.fetch_req_en", 32'(bus.fetch_req_en), 0);
    chk("rst.fetch_req_addr", bus.fetch_req_addr, 0);
    chk("rst.result", bus.result, 0);
    chk("rst.fault", 32'(bus.fault), 0);
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      rf[tbl[i].ins[19:15]] = tbl[i].r1;
      rf[tbl[i].ins[24:20]] = tbl[i].r2;
      rf[0] = 0;
      issue(tbl[i].pc, tbl[i].ins, tbl[i].dly, lat, nreq);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'(5 + tbl[i].dly));
      chk($sformatf("v%0d.nreq", i), 32'(nreq), 1);
      chk($sformatf("v%0d.result", i), bus.result, tbl[i].res);
      chk($sformatf("v%0d.jump_dest", i), bus.jump_dest, tbl[i].jd);
      chk($sformatf("v%0d.jump_taken", i), 32'(bus.jump_taken), 32'(tbl[i].jt));
      chk($sformatf("v%0d.rd_we", i), 32'(bus.rd_we), 32'(tbl[i].we));
      chk($sformatf("v%0d.illegal", i), 32'(bus.illegal), 32'(tbl[i].ill));
      chk($sformatf("v%0d.fault", i), 32'(bus.fault), 0);
    end

    // Misaligned PC: no fetch, done in cycle 1 with fault and zeroed results
    issue(32'h102, 32'h00500093, 0, lat, nreq);
    chk("mis.latency", 32'(lat), 1);
    chk("mis.nreq", 32'(nreq), 0);
    chk("mis.fault", 32'(bus.fault), 1);
    chk("mis.result", bus.result, 0);
    chk("mis.rd_we", 32'(bus.rd_we), 0);

    // No response: FETCH_WAIT spans cycles 2..256, fault-done in cycle 257
    issue(32'h500, 32'h0, -1, lat, nreq);
    chk("tmo.latency", 32'(lat), 257);
    chk("tmo.nreq", 32'(nreq), 1);
    chk("tmo.fault", 32'(bus.fault), 1);
    chk("tmo.rd_we", 32'(bus.rd_we), 0);
    chk("tmo.jump_taken", 32'(bus.jump_taken), 0);
    chk("tmo.result", bus.result, 0);

    // Successful instruction after a fault clears fault
    rf[1] = 32'd9;
    issue(32'h104, 32'h00308113, 0, lat, nreq);
    chk("post_tmo.fault", 32'(bus.fault), 0);
    chk("post_tmo.result", bus.result, 32'd12);

    // Reset while waiting for the fetch response
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pc = 32'h300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.done", 32'(bus.done), 0);
    chk("midrst.result", bus.result, 0);
    chk("midrst.pc_out", bus.pc_out, 0);
    chk("midrst.rd_we", 32'(bus.rd_we), 0);
    chk("midrst.fetch_req_addr", bus.fetch_req_addr, 0);
    bus.fetch_resp_en = 1'b1; bus.fetch_resp_data = 32'h00500093;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.fetch_resp_en = 1'b0;
      if (bus.done || bus.fetch_req_en) ndone++;
    end
    chk("midrst.no_activity", 32'(ndone), 0);
    issue(32'h100, 32'h00500093, 0, lat, nreq);
    chk("midrst.next_latency", 32'(lat), 5);
    chk("midrst.next_result", bus.result, 32'd5);

    // Random instructions against the ISA-level model
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
    for (int n = 0; n < 120; n++) begin
      int dly;
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      body = $urandom;
      case ($urandom_range(0, 3))
        0: f7s = 7'h00;
        1: f7s = 7'h20;
        2: f7s = 7'h01;
        default: f7s = body[31:25];
      endcase
      ins = {f7s, body[24:7], ops[$urandom_range(0, 10)]};
      if ($urandom_range(0, 2) == 0) rf[ins[24:20]] = rf[ins[19:15]];
      rf[0] = 0;
      p = $urandom;
      p[1:0] = 2'b00;
      dly = $urandom_range(0, 3);
      issue(p, ins, dly, lat, nreq);
      chk("rnd.latency", 32'(lat), 32'(5 + dly));
      check_model(p, ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
